seven_seg_scan: RTL

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 107 ++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner: cycles one digit per slot
// with a leading guard gap, double-buffers the shown value so a frame never
// tears, and optionally blanks leading zeros.
module seven_seg_scan #(
    parameter int unsigned CLKS_PER_DIGIT = 50000,
    parameter int unsigned GUARD_CLKS     = 2,
    parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [15:0] i_Value,
    input  logic        i_Value_Valid,
    input  logic [3:0]  i_Dp,
    input  logic        i_Blank_Lead_Zero,
    output logic [3:0]  o_Nibble,
    output logic [3:0]  o_Digit_En,
    output logic        o_Dp,
    output logic        o_Frame_Start
);

    localparam int unsigned TICK_W   = $clog2(CLKS_PER_DIGIT);
    localparam logic [3:0]  EN_OFF   = EN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [TICK_W-1:0] r_Tick;
    logic [1:0]        r_Idx;
    logic [15:0]       r_Disp_Val;
    logic [3:0]        r_Disp_Dp;
    logic [15:0]       r_Pend_Val;
    logic [3:0]        r_Pend_Dp;
    logic              r_Pend_Flag;
    logic              r_Wrap_D;

    logic              w_Term;
    logic              w_Boundary;
    logic [3:0]        w_Blank;
    logic              w_On;
    logic [3:0]        w_Onehot;
    logic [3:0]        w_Nibble;

    // Slot timing, blanking and enable decode for the current digit
    always_comb begin
        w_Term     = (r_Tick == TICK_W'(CLKS_PER_DIGIT - 1));
        w_Boundary = w_Term && (r_Idx == 2'd3);
        w_Blank    = 4'b0000;
        w_Blank[1] = i_Blank_Lead_Zero && (r_Disp_Val[15:4]  == 12'h000);
        w_Blank[2] = i_Blank_Lead_Zero && (r_Disp_Val[15:8]  == 8'h00);
        w_Blank[3] = i_Blank_Lead_Zero && (r_Disp_Val[15:12] == 4'h0);
        w_On       = (r_Tick >= TICK_W'(GUARD_CLKS)) && !w_Blank[r_Idx];
        w_Onehot   = 4'b0001 << r_Idx;
        w_Nibble   = r_Disp_Val[{r_Idx, 2'b00} +: 4];
    end

    // Slot counter and digit index
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Tick <= '0;
            r_Idx  <= 2'd0;
        end else if (w_Term) begin
            r_Tick <= '0;
            r_Idx  <= r_Idx + 2'd1;
        end else begin
            r_Tick <= r_Tick + TICK_W'(1);
        end
    end

    // Pending/display double buffer; display only changes on a frame boundary
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Disp_Val  <= 16'h0000;
            r_Disp_Dp   <= 4'h0;
            r_Pend_Val  <= 16'h0000;
            r_Pend_Dp   <= 4'h0;
            r_Pend_Flag <= 1'b0;
        end else if (w_Boundary) begin
            if (i_Value_Valid) begin
                r_Disp_Val <= i_Value;
                r_Disp_Dp  <= i_Dp;
            end else if (r_Pend_Flag) begin
                r_Disp_Val <= r_Pend_Val;
                r_Disp_Dp  <= r_Pend_Dp;
            end
            r_Pend_Flag <= 1'b0;
        end else if (i_Value_Valid) begin
            r_Pend_Val  <= i_Value;
            r_Pend_Dp   <= i_Dp;
            r_Pend_Flag <= 1'b1;
        end
    end

    // Registered outputs, one cycle behind the slot state
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Wrap_D      <= 1'b0;
            o_Nibble      <= 4'h0;
            o_Digit_En    <= EN_OFF;
            o_Dp          <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else begin
            r_Wrap_D      <= w_Boundary;
            o_Nibble      <= w_Nibble;
            o_Digit_En    <= w_On ? (w_Onehot ^ EN_OFF) : EN_OFF;
            o_Dp          <= r_Disp_Dp[r_Idx] && w_On;
            o_Frame_Start <= r_Wrap_D;
        end
    end

endmodule
